req_pending_ctrl: RTL and testbench

Upstream request-capture and grant sequencer for the 16-to-4 priority encoder. Turns 16 asynchronous-to-the-encoder request lines into sticky pending bits, presents the unmasked pending vector and an enable to the encoder, captures the returned index, and hands it out over a valid/ready grant interface. When the grant is accepted, the served pending bit is cleared. The encoder itself stays purely combinational and external to this block.

---
 rtl/req_pending_ctrl_pkg.sv | 21 ++
 rtl/req_pending_ctrl_edge_detect.sv | 29 ++
 rtl/req_pending_ctrl.sv | 95 +++++++++
 tb/tb_req_pending_ctrl.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/req_pending_ctrl_pkg.sv
// Shared widths, FSM state type and helpers for the request-pending controller.
// Imported by the edge detector and the top-level sequencer.
package req_pending_ctrl_pkg;

    localparam int N_REQ = 16;
    localparam int IDX_W = 4;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_e;

    // Produces the single-bit mask that clears one served pending bit.
    function automatic logic [N_REQ-1:0] onehot(input logic [IDX_W-1:0] idx);
        logic [N_REQ-1:0] vec;
        vec      = '0;
        vec[idx] = 1'b1;
        return vec;
    endfunction

endpackage

// File: rtl/req_pending_ctrl_edge_detect.sv
// Rising-edge detector for the request lines: one registered copy of req.
// A line that stays high produces exactly one single-cycle pulse.
module req_edge_detect
    import req_pending_ctrl_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N_REQ-1:0] req,
    output logic [N_REQ-1:0] req_rise
);

    logic [N_REQ-1:0] req_d_q;
    logic [N_REQ-1:0] req_d_d;

    always_comb begin
        req_d_d = req;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            req_d_q <= '0;
        end else begin
            req_d_q <= req_d_d;
        end
    end

    assign req_rise = req & ~req_d_q;

endmodule

// File: rtl/req_pending_ctrl.sv
// Captures request edges into sticky pending bits, samples the external
// priority encoder once per grant and offers the result over valid/ready.
module req_pending_ctrl
    import req_pending_ctrl_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N_REQ-1:0] req,
    input  logic [N_REQ-1:0] mask,
    input  logic             clr_all,
    output logic [N_REQ-1:0] enc_w,
    output logic             enc_en,
    input  logic [IDX_W-1:0] enc_y,
    output logic             grant_valid,
    output logic [IDX_W-1:0] grant_idx,
    input  logic             grant_ready,
    output logic [N_REQ-1:0] pending,
    output logic             overflow
);

    logic [N_REQ-1:0] req_rise;

    state_e           state_q, state_d;
    logic [IDX_W-1:0] grant_idx_q, grant_idx_d;
    logic [N_REQ-1:0] pending_q, pending_d;
    logic             overflow_q, overflow_d;

    logic             handshake;
    logic [N_REQ-1:0] clr_vec;

    req_edge_detect u_edge (
        .clk      (clk),
        .rst_n    (rst_n),
        .req      (req),
        .req_rise (req_rise)
    );

    assign enc_w       = pending_q & ~mask;
    assign enc_en      = (state_q == IDLE);
    assign grant_valid = (state_q == GRANT);
    assign grant_idx   = grant_idx_q;
    assign pending     = pending_q;
    assign overflow    = overflow_q;

    assign handshake = (state_q == GRANT) && grant_ready;
    assign clr_vec   = handshake ? onehot(grant_idx_q) : '0;

    // Set wins over the handshake clear, and such a collision is not an overflow.
    always_comb begin
        pending_d  = (pending_q & ~clr_vec) | req_rise;
        overflow_d = overflow_q | (|(req_rise & pending_q & ~clr_vec));
        if (clr_all) begin
            pending_d  = '0;
            overflow_d = 1'b0;
        end
    end

    // |enc_w is required because the encoder also answers 0 for an empty vector.
    always_comb begin
        state_d     = state_q;
        grant_idx_d = grant_idx_q;
        unique case (state_q)
            IDLE: begin
                if (|enc_w) begin
                    state_d     = GRANT;
                    grant_idx_d = enc_y;
                end
            end
            GRANT: begin
                if (grant_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        if (clr_all) begin
            state_d = IDLE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            grant_idx_q <= '0;
            pending_q   <= '0;
            overflow_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            grant_idx_q <= grant_idx_d;
            pending_q   <= pending_d;
            overflow_q  <= overflow_d;
        end
    end

endmodule

// File: tb/tb_req_pending_ctrl.sv
// Directed, table-driven bench for req_pending_ctrl with a behavioural
// model of the external 16-to-4 priority encoder.
module tb_req_pending_ctrl;
    import req_pending_ctrl_pkg::*;

    logic             clk;
    logic             rst_n;
    logic [N_REQ-1:0] req;
    logic [N_REQ-1:0] mask;
    logic             clr_all;
    logic [N_REQ-1:0] enc_w;
    logic             enc_en;
    logic [IDX_W-1:0] enc_y;
    logic             grant_valid;
    logic [IDX_W-1:0] grant_idx;
    logic             grant_ready;
    logic [N_REQ-1:0] pending;
    logic             overflow;

    int checkCount;
    int passCount;

    typedef struct {
        logic [15:0] req;
        logic [15:0] mask;
        logic        clr;
        logic        rdy;
        logic [15:0] expPending;
        logic        expValid;
        logic [3:0]  expIdx;
        logic        expOvf;
    } vec_t;

    vec_t vecs[$];

    req_pending_ctrl dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req         (req),
        .mask        (mask),
        .clr_all     (clr_all),
        .enc_w       (enc_w),
        .enc_en      (enc_en),
        .enc_y       (enc_y),
        .grant_valid (grant_valid),
        .grant_idx   (grant_idx),
        .grant_ready (grant_ready),
        .pending     (pending),
        .overflow    (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // External encoder: index of the highest set bit, 0 when empty.
    always_comb begin
        enc_y = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (enc_w[i]) enc_y = 4'(i);
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checkCount++;
        if (actual === expected) begin
            passCount++;
        end else begin
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic [15:0] r, input logic [15:0] m,
                                 input logic c, input logic rdy);
        req         = r;
        mask        = m;
        clr_all     = c;
        grant_ready = rdy;
        @(posedge clk);
        #1;
    endtask

    task automatic addVec(input logic [15:0] r, input logic [15:0] m, input logic c,
                          input logic rdy, input logic [15:0] p, input logic v,
                          input logic [3:0] idx, input logic o);
        vec_t t;
        t.req = r; t.mask = m; t.clr = c; t.rdy = rdy;
        t.expPending = p; t.expValid = v; t.expIdx = idx; t.expOvf = o;
        vecs.push_back(t);
    endtask

    initial begin
        checkCount  = 0;
        passCount   = 0;
        rst_n       = 1'b0;
        req         = '0;
        mask        = '0;
        clr_all     = 1'b0;
        grant_ready = 1'b0;

        //     req      mask     clr  rdy  pending  valid idx ovf
        // single request on line 5
        addVec(16'h0020, 16'h0000, 0, 0, 16'h0020, 0, 4'd0,  0);
        addVec(16'h0000, 16'h0000, 0, 0, 16'h0020, 1, 4'd5,  0);
        addVec(16'h0000, 16'h0000, 0, 1, 16'h0000, 0, 4'd5,  0);
        // priority 12 over 3
        addVec(16'h1008, 16'h0000, 0, 0, 16'h1008, 0, 4'd5,  0);
        addVec(16'h1008, 16'h0000, 0, 0, 16'h1008, 1, 4'd12, 0);
        addVec(16'h1008, 16'h0000, 0, 1, 16'h0008, 0, 4'd12, 0);
        addVec(16'h1008, 16'h0000, 0, 0, 16'h0008, 1, 4'd3,  0);
        addVec(16'h1008, 16'h0000, 0, 1, 16'h0000, 0, 4'd3,  0);
        addVec(16'h0000, 16'h0000, 0, 0, 16'h0000, 0, 4'd3,  0);
        // masking line 9
        addVec(16'h0204, 16'h0200, 0, 0, 16'h0204, 0, 4'd3,  0);
        addVec(16'h0000, 16'h0200, 0, 0, 16'h0204, 1, 4'd2,  0);
        addVec(16'h0000, 16'h0200, 0, 1, 16'h0200, 0, 4'd2,  0);
        addVec(16'h0000, 16'h0200, 0, 0, 16'h0200, 0, 4'd2,  0);
        addVec(16'h0000, 16'h0000, 0, 0, 16'h0200, 1, 4'd9,  0);
        addVec(16'h0000, 16'h0000, 0, 1, 16'h0000, 0, 4'd9,  0);
        // overflow on line 7, then clear
        addVec(16'h0080, 16'h0000, 0, 0, 16'h0080, 0, 4'd9,  0);
        addVec(16'h0000, 16'h0000, 0, 0, 16'h0080, 1, 4'd7,  0);
        addVec(16'h0080, 16'h0000, 0, 0, 16'h0080, 1, 4'd7,  1);
        addVec(16'h0080, 16'h0000, 1, 0, 16'h0000, 0, 4'd7,  0);
        // set wins over handshake clear
        addVec(16'h0000, 16'h0000, 0, 0, 16'h0000, 0, 4'd7,  0);
        addVec(16'h0080, 16'h0000, 0, 0, 16'h0080, 0, 4'd7,  0);
        addVec(16'h0000, 16'h0000, 0, 0, 16'h0080, 1, 4'd7,  0);
        addVec(16'h0080, 16'h0000, 0, 1, 16'h0080, 0, 4'd7,  0);
        addVec(16'h0080, 16'h0000, 0, 0, 16'h0080, 1, 4'd7,  0);
        addVec(16'h0000, 16'h0000, 0, 1, 16'h0000, 0, 4'd7,  0);
        // abort with clr_all; edge in the clear cycle is lost
        addVec(16'h0010, 16'h0000, 0, 0, 16'h0010, 0, 4'd7,  0);
        addVec(16'h0010, 16'h0000, 0, 0, 16'h0010, 1, 4'd4,  0);
        addVec(16'h0010, 16'h0000, 0, 0, 16'h0010, 1, 4'd4,  0);
        addVec(16'h0000, 16'h0000, 0, 0, 16'h0010, 1, 4'd4,  0);
        addVec(16'h0010, 16'h0000, 1, 0, 16'h0000, 0, 4'd4,  0);
        addVec(16'h0010, 16'h0000, 0, 0, 16'h0000, 0, 4'd4,  0);
        addVec(16'h0000, 16'h0000, 0, 0, 16'h0000, 0, 4'd4,  0);
        // masking during GRANT keeps the offered index
        addVec(16'h0006, 16'h0000, 0, 0, 16'h0006, 0, 4'd4,  0);
        addVec(16'h0000, 16'h0000, 0, 0, 16'h0006, 1, 4'd2,  0);
        addVec(16'h0000, 16'h0004, 0, 0, 16'h0006, 1, 4'd2,  0);
        addVec(16'h0000, 16'h0004, 0, 1, 16'h0002, 0, 4'd2,  0);
        addVec(16'h0000, 16'h0004, 0, 0, 16'h0002, 1, 4'd1,  0);
        addVec(16'h0000, 16'h0000, 0, 1, 16'h0000, 0, 4'd1,  0);

        repeat (2) @(posedge clk);
        #1;
        checkOutput("reset pending",   32'(pending),     32'h0);
        checkOutput("reset valid",     32'(grant_valid), 32'h0);
        checkOutput("reset idx",       32'(grant_idx),   32'h0);
        checkOutput("reset overflow",  32'(overflow),    32'h0);
        checkOutput("reset enc_en",    32'(enc_en),      32'h1);
        checkOutput("reset enc_w",     32'(enc_w),       32'h0);

        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        for (int i = 0; i < vecs.size(); i++) begin
            applyStimulus(vecs[i].req, vecs[i].mask, vecs[i].clr, vecs[i].rdy);
            checkOutput($sformatf("row%0d pending", i),  32'(pending),     32'(vecs[i].expPending));
            checkOutput($sformatf("row%0d valid", i),    32'(grant_valid), 32'(vecs[i].expValid));
            checkOutput($sformatf("row%0d idx", i),      32'(grant_idx),   32'(vecs[i].expIdx));
            checkOutput($sformatf("row%0d overflow", i), 32'(overflow),    32'(vecs[i].expOvf));
            checkOutput($sformatf("row%0d enc_en", i),   32'(enc_en),      32'(!vecs[i].expValid));
            checkOutput($sformatf("row%0d enc_w", i),    32'(enc_w),
                        32'(vecs[i].expPending & ~vecs[i].mask));
        end

        // asynchronous reset while a grant (idx 8) is being offered
        applyStimulus(16'h0100, 16'h0000, 0, 0);
        applyStimulus(16'h0100, 16'h0000, 0, 0);
        applyStimulus(16'h0180, 16'h0000, 0, 0);
        checkOutput("pre-reset valid",    32'(grant_valid), 32'h1);
        checkOutput("pre-reset idx",      32'(grant_idx),   32'h8);
        checkOutput("pre-reset overflow", 32'(overflow),    32'h0);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("async valid",    32'(grant_valid), 32'h0);
        checkOutput("async idx",      32'(grant_idx),   32'h0);
        checkOutput("async pending",  32'(pending),     32'h0);
        checkOutput("async overflow", 32'(overflow),    32'h0);
        checkOutput("async enc_en",   32'(enc_en),      32'h1);
        req = '0;
        @(negedge clk);
        rst_n = 1'b1;
        applyStimulus(16'h0000, 16'h0000, 0, 0);
        checkOutput("post-reset pending", 32'(pending),     32'h0);
        checkOutput("post-reset valid",   32'(grant_valid), 32'h0);

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
